// File: rtl/stw_bist_controller_pkg.sv
// stw_bist_controller_pkg: FSM state encoding and the fixed STW pattern table.
package stw_bist_controller_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;
  localparam logic [3:0][15:0] PAT_OP1 = {16'h00FF, 16'h5555, 16'hFFFF, 16'h0003};
  localparam logic [3:0][15:0] PAT_OP2 = {16'h0100, 16'h0002, 16'h0001, 16'h0005};
  localparam logic [3:0][15:0] PAT_ADD = {16'h00FF, 16'h0000, 16'h0001, 16'h0007};
endpackage

// File: rtl/stw_bist_controller_pattern_rom.sv
// stw_pattern_rom: combinational map from pattern index to {op1, op2, add, expected MAC}.
module stw_pattern_rom
  import stw_bist_controller_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [1:0]           idx_i,
  output logic [WORD_SIZE-1:0] op1_o,
  output logic [WORD_SIZE-1:0] op2_o,
  output logic [WORD_SIZE-1:0] add_o,
  output logic [WORD_SIZE-1:0] exp_o
);
  assign op1_o = WORD_SIZE'(PAT_OP1[idx_i]);
  assign op2_o = WORD_SIZE'(PAT_OP2[idx_i]);
  assign add_o = WORD_SIZE'(PAT_ADD[idx_i]);
  assign exp_o = op1_o * op2_o + add_o;
endmodule

// File: rtl/stw_bist_controller.sv
// stw_bist_controller: steps the STW pattern table through the array and collects a sticky fault map.
// Optional WAIT watchdog enabled by defining STW_TIMEOUT_EN.
module stw_bist_controller
  import stw_bist_controller_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int WORD_SIZE      = 16,
  parameter int NUM_PATTERNS   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bist_start,
  input  logic                   bist_abort,
  output logic [WORD_SIZE-1:0]   STW_mult_op1,
  output logic [WORD_SIZE-1:0]   STW_mult_op2,
  output logic [WORD_SIZE-1:0]   STW_add_op,
  output logic [WORD_SIZE-1:0]   STW_expected,
  output logic                   STW_test_load_en,
  output logic                   STW_start,
  input  logic                   STW_complete_out,
  input  logic [ROWS*COLS-1:0]   STW_result_mat,
  output logic                   array_test_mode,
  output logic                   bist_busy,
  output logic                   bist_done,
  output logic                   bist_pass,
  output logic                   timeout_err,
  output logic [ROWS*COLS-1:0]   fault_map
);
  localparam int N = ROWS * COLS;
  state_e               state_q, state_d;
  logic [3:0]           pat_q, pat_d;
  logic                 armed_q, armed_d, pass_q, pass_d, terr_q, terr_d;
  logic                 accept, last, expire;
  logic [N-1:0]         fmap_q, fmap_d;
  logic [WORD_SIZE-1:0] op1_q, op2_q, add_q, exp_q;
  logic [WORD_SIZE-1:0] rom_op1, rom_op2, rom_add, rom_exp;

  stw_pattern_rom #(.WORD_SIZE(WORD_SIZE)) u_rom (
    .idx_i(pat_d[1:0]),
    .op1_o(rom_op1),
    .op2_o(rom_op2),
    .add_o(rom_add),
    .exp_o(rom_exp)
  );

  // Complete counts only after it has been seen low in this WAIT, so a stale one is ignored.
  assign accept = state_q == WAIT && armed_q && STW_complete_out;
  assign last   = pat_q == 4'(NUM_PATTERNS - 1);

`ifdef STW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q;
  assign expire = state_q == WAIT && cnt_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) cnt_q <= (rst || state_q != WAIT) ? '0 : cnt_q + 1'b1;
`else
  assign expire = TIMEOUT_CYCLES < 0;
`endif

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    armed_d = armed_q;
    fmap_d  = fmap_q;
    terr_d  = terr_q;
    pass_d  = pass_q;
    if (state_q != IDLE && bist_abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (bist_start && !bist_abort) begin
          state_d = LOAD;
          pat_d   = '0;
          fmap_d  = '0;
          terr_d  = 1'b0;
          pass_d  = 1'b0;
        end
        LOAD: state_d = START;
        START: begin
          state_d = WAIT;
          armed_d = 1'b0;
        end
        WAIT: begin
          armed_d = armed_q | ~STW_complete_out;
          if (accept) begin
            fmap_d  = fmap_q | STW_result_mat;
            state_d = last ? DONE : LOAD;
            pat_d   = last ? pat_q : pat_q + 4'd1;
          end else if (expire) begin
            terr_d  = 1'b1;
            fmap_d  = '1;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == DONE && state_q != DONE) pass_d = fmap_d == '0 && !terr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      armed_q <= 1'b0;
      fmap_q  <= '0;
      terr_q  <= 1'b0;
      pass_q  <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      add_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      armed_q <= armed_d;
      fmap_q  <= fmap_d;
      terr_q  <= terr_d;
      pass_q  <= pass_d;
      if (state_d == LOAD) begin
        op1_q <= rom_op1;
        op2_q <= rom_op2;
        add_q <= rom_add;
        exp_q <= rom_exp;
      end
    end
  end

  assign STW_mult_op1     = op1_q;
  assign STW_mult_op2     = op2_q;
  assign STW_add_op       = add_q;
  assign STW_expected     = exp_q;
  assign STW_test_load_en = state_q == LOAD;
  assign STW_start        = state_q == START;
  assign bist_busy        = state_q != IDLE;
  assign array_test_mode  = bist_busy;
  assign bist_done        = state_q == DONE && !bist_abort;
  assign bist_pass        = pass_q;
  assign timeout_err      = terr_q;
  assign fault_map        = fmap_q;
endmodule

// File: tb/tb_stw_bist_controller.sv
// tb_stw_bist_controller: directed runs against a cycle-level behavioural model of the BIST sequence.
module tb_stw_bist_controller;
  localparam int NP = 4;
  localparam int TO = 64;
`ifdef STW_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, bist_start, bist_abort;
  logic [15:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
  logic        STW_test_load_en, STW_start, STW_complete_out;
  logic [15:0] STW_result_mat, fault_map;
  logic        array_test_mode, bist_busy, bist_done, bist_pass, timeout_err;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  stw_bist_controller dut (
    .clk(clk), .rst(rst), .bist_start(bist_start), .bist_abort(bist_abort),
    .STW_mult_op1(STW_mult_op1), .STW_mult_op2(STW_mult_op2), .STW_add_op(STW_add_op),
    .STW_expected(STW_expected), .STW_test_load_en(STW_test_load_en), .STW_start(STW_start),
    .STW_complete_out(STW_complete_out), .STW_result_mat(STW_result_mat),
    .array_test_mode(array_test_mode), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_pass(bist_pass), .timeout_err(timeout_err), .fault_map(fault_map)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Array stand-in. mode 0: complete low from START, high on 3rd WAIT cycle.
  // mode 1: stale high through START/WAIT1, low on WAIT2, high from WAIT3. mode 2: never completes.
  int          mode = 0, ph = 1000, n_load = 0, n_done = 0;
  logic        fault_en = 1'b0;
  logic [15:0] seen_op1 = '0, last_exp = '0;
  always @(negedge clk) begin
    if (STW_test_load_en) begin
      seen_op1 = STW_mult_op1;
      last_exp = STW_expected;
      n_load++;
    end
    if (bist_done) n_done++;
    ph = STW_start ? 0 : (ph < 1000 ? ph + 1 : ph);
    STW_complete_out = mode == 2 ? 1'b0 : mode == 1 ? (ph != 2) : (ph >= 3);
    STW_result_mat = (STW_complete_out && fault_en && seen_op1 == 16'h5555) ? 16'h0040 : 16'h0000;
  end

  // Behavioural model: a run is a sequence of patterns, each cycle k=0 load, k=1 start, k>=2 waiting.
  logic [15:0] t_op1[4] = '{16'h0003, 16'hFFFF, 16'h5555, 16'h00FF};
  logic [15:0] t_op2[4] = '{16'h0005, 16'h0001, 16'h0002, 16'h0100};
  logic [15:0] t_add[4] = '{16'h0007, 16'h0001, 16'h0000, 16'h00FF};
  bit          m_run = 0, m_done = 0, m_low = 0, m_terr = 0, m_pass = 0;
  int          m_k = 0, m_idx = 0;
  logic [15:0] m_fmap = '0, m_op1 = '0, m_op2 = '0, m_add = '0, m_exp;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_done = 0; m_k = 0; m_idx = 0; m_terr = 0; m_pass = 0;
      m_fmap = '0; m_op1 = '0; m_op2 = '0; m_add = '0;
    end else if (!m_run && !m_done) begin
      if (bist_start && !bist_abort) begin
        m_run = 1; m_k = 0; m_idx = 0; m_fmap = '0; m_terr = 0; m_pass = 0;
        m_op1 = t_op1[0]; m_op2 = t_op2[0]; m_add = t_add[0];
      end
    end else if (bist_abort) begin
      m_run = 0; m_done = 0;
    end else if (m_done) m_done = 0;
    else if (m_k == 0) m_k = 1;
    else if (m_k == 1) begin
      m_k = 2; m_low = 0;
    end else if (STW_complete_out && m_low) begin
      m_fmap |= STW_result_mat;
      if (m_idx == NP - 1) begin
        m_run = 0; m_done = 1; m_pass = m_fmap == 0 && !m_terr;
      end else begin
        m_idx++; m_k = 0;
        m_op1 = t_op1[m_idx]; m_op2 = t_op2[m_idx]; m_add = t_add[m_idx];
      end
    end else if (TMO && m_k - 1 == TO) begin
      m_terr = 1; m_fmap = '1; m_run = 0; m_done = 1; m_pass = 0;
    end else begin
      m_low = m_low | !STW_complete_out;
      m_k++;
    end
  end

  always @(negedge clk) begin
    #1;
    m_exp = 16'(m_op1 * m_op2 + m_add);
    chk("ctrl", {STW_test_load_en, STW_start, array_test_mode, bist_busy, bist_done, bist_pass, timeout_err},
        {m_run && m_k == 0, m_run && m_k == 1, m_run || m_done, m_run || m_done, m_done && !bist_abort, m_pass, m_terr});
    chk("fault_map", fault_map, m_fmap);
    chk("operands", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, {m_op1, m_op2, m_add, m_exp});
  end

  task automatic go;
    @(negedge clk) bist_start = 1'b1;
    @(negedge clk) bist_start = 1'b0;
  endtask

  task automatic run_to_done(input int t0, output int t);
    t = t0;
    while (!bist_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bist_done) chk("done_never_came", 0, 1);
  endtask

  int t, l0, d0;
  initial begin
    rst = 1'b1; bist_start = 1'b0; bist_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {STW_test_load_en, STW_start, array_test_mode, bist_busy, bist_done, bist_pass, timeout_err}, 0);
    chk("reset_ops", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected, fault_map}, 0);
    rst = 1'b0;
    // Clean run
    l0 = n_load; d0 = n_done;
    go();
    chk("p0_load_ops", {STW_test_load_en, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected},
        {1'b1, 16'h0003, 16'h0005, 16'h0007, 16'h0016});
    run_to_done(1, t);
    chk("clean_len", t, 21);
    chk("clean_pass", {bist_pass, fault_map}, {1'b1, 16'h0000});
    repeat (2) @(negedge clk);
    chk("clean_loads", n_load - l0, 4);
    chk("clean_dones", n_done - d0, 1);
    chk("p3_expected", last_exp, 16'hFFFF);
    chk("pass_held", {bist_busy, bist_pass}, 2'b01);
    // Fault on PE r1,c2 during P2
    fault_en = 1'b1;
    go();
    run_to_done(1, t);
    chk("fault_map", {bist_pass, fault_map}, {1'b0, 16'h0040});
    fault_en = 1'b0;
    // Stale complete
    mode = 1;
    repeat (2) @(negedge clk);
    go();
    run_to_done(1, t);
    chk("stale_len", t, 21);
    chk("stale_pass", bist_pass, 1'b1);
    mode = 0;
    // Abort in WAIT of P1
    repeat (2) @(negedge clk);
    d0 = n_done;
    go();
    repeat (7) @(negedge clk);
    chk("in_p1_wait", {bist_busy, STW_mult_op1}, {1'b1, 16'hFFFF});
    bist_abort = 1'b1;
    @(negedge clk) bist_abort = 1'b0;
    chk("abort_idle", bist_busy, 1'b0);
    repeat (25) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    // Start and abort together in IDLE
    @(negedge clk) begin bist_start = 1'b1; bist_abort = 1'b1; end
    @(negedge clk) begin bist_start = 1'b0; bist_abort = 1'b0; end
    chk("start_abort_idle", bist_busy, 1'b0);
    // Reset during WAIT of P3 after a fault has been recorded
    fault_en = 1'b1;
    go();
    repeat (17) @(negedge clk);
    chk("pre_rst_fmap", fault_map, 16'h0040);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst_ctrl", {STW_test_load_en, STW_start, array_test_mode, bist_busy, bist_done, bist_pass, timeout_err}, 0);
    chk("rst_ops", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected, fault_map}, 0);
    fault_en = 1'b0;
    // Start while busy
    repeat (2) @(negedge clk);
    l0 = n_load; d0 = n_done;
    go();
    repeat (2) @(negedge clk);
    bist_start = 1'b1;
    @(negedge clk) bist_start = 1'b0;
    run_to_done(4, t);
    chk("busy_start_len", t, 21);
    repeat (4) @(negedge clk);
    chk("busy_start_loads", n_load - l0, 4);
    chk("busy_start_dones", n_done - d0, 1);
`ifdef STW_TIMEOUT_EN
    mode = 2;
    go();
    run_to_done(1, t);
    chk("timeout_len", t, 67);
    chk("timeout_flags", {timeout_err, bist_pass, fault_map}, {1'b1, 1'b0, 16'hFFFF});
    mode = 0;
    repeat (2) @(negedge clk);
    go();
    chk("timeout_cleared", {timeout_err, fault_map}, 0);
    run_to_done(1, t);
    chk("after_timeout_pass", bist_pass, 1'b1);
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
